// File: rtl/activation_backward.sv
// ---------------------------------------------------------------------------
// activation_backward
//
// Backward pass of the sigmoid activation unit. Given a forward activation
// a = sigmoid(x) and an upstream error e (both Q8.8), it produces the
// backpropagated delta e * a * (1 - a) in Q8.8 through a two-stage pipeline
// with valid/ready flow control on both sides and a single global stall.
//
// Build option:
//   ACT_BWD_ROUND_EN  defined   -> round-half-up (+0x80) before each >>8
//                     undefined -> plain truncation toward -infinity
//   Pipeline depth, handshake and reset behaviour are the same in both builds.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous, active-high reset (highest priority)
//   in_valid   in   1   in_act / in_err carry a sample
//   in_ready   out  1   pipeline advances this cycle (accepts input)
//   in_act     in   16  forward activation, Q8.8 unsigned (0x0000..0x0100)
//   in_err     in   16  upstream error, Q8.8 two's complement
//   out_valid  out  1   out_delta carries a result
//   out_ready  in   1   downstream takes out_delta this cycle
//   out_delta  out  16  delta, Q8.8 two's complement
//   out_count  out  16  output handshakes since reset, wraps at 0xFFFF
// ---------------------------------------------------------------------------
module activation_backward (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_act,
    input  logic [15:0] in_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_delta,
    output logic [15:0] out_count
);

    // 1.0 in Q8.8; the activation is clamped into [0, ONE_Q88].
    localparam logic [15:0] ONE_Q88 = 16'h0100;
    localparam logic [8:0]  ONE_9B  = 9'h100;

`ifdef ACT_BWD_ROUND_EN
    // Half an LSB of the value about to be shifted right by 8.
    localparam logic [16:0]        RND_U = 17'h0_0080;
    localparam logic signed [22:0] RND_S = 23'sh00_0080;
`else
    localparam logic [16:0]        RND_U = 17'h0_0000;
    localparam logic signed [22:0] RND_S = 23'sh00_0000;
`endif

    // -----------------------------------------------------------------------
    // Flow control: one stall signal for the whole pipe. Bubbles are not
    // collapsed, so an empty stage 1 still waits for adv.
    // -----------------------------------------------------------------------
    logic adv;

    // Stage 1 state: derivative term and the error it will scale.
    logic              s1_valid_q, s1_valid_d;
    logic [6:0]        s1_d_q,     s1_d_d;
    logic [15:0]       s1_e_q,     s1_e_d;

    // Stage 2 state: the visible output register.
    logic              out_valid_q, out_valid_d;
    logic [15:0]       out_delta_q, out_delta_d;
    logic [15:0]       out_count_q, out_count_d;

    // Stage 0 combinational datapath.
    logic [8:0]        act_clamped;
    logic [8:0]        one_minus_a;
    logic [16:0]       prod_u;
    logic [16:0]       prod_u_rnd;
    logic [6:0]        deriv;

    // Stage 2 combinational datapath.
    logic signed [22:0] err_ext;
    logic signed [22:0] deriv_ext;
    logic signed [22:0] prod_s;
    logic signed [22:0] prod_s_rnd;
    logic signed [22:0] prod_s_shr;
    logic [15:0]        delta;

    logic out_xfer;

    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = adv;
    assign out_xfer = out_valid_q & out_ready;

    // -----------------------------------------------------------------------
    // Stage 0: clamp the activation, then a * (1 - a).
    // Negative encodings (bit 15 set) are treated as 0, anything above 1.0
    // saturates to 1.0; both ends give a zero derivative.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a value on every path first so
        // no latch is inferred when a branch is missed.
        act_clamped = 9'h000;
        if (in_act[15]) begin
            act_clamped = 9'h000;
        end else if (in_act > ONE_Q88) begin
            act_clamped = ONE_9B;
        end else begin
            act_clamped = in_act[8:0];
        end

        one_minus_a = ONE_9B - act_clamped;

        // Max 0x80 * 0x80 = 0x4000, comfortably inside 17 bits.
        prod_u     = {8'h00, act_clamped} * {8'h00, one_minus_a};
        prod_u_rnd = prod_u + RND_U;

        // (0x4000 + 0x80) >> 8 = 0x40, so bits [14:8] hold the full result.
        deriv = prod_u_rnd[14:8];
    end

    // -----------------------------------------------------------------------
    // Stage 2 datapath: signed(e) * d, then arithmetic shift back to Q8.8.
    // |d| <= 0x40 means |result| <= |e|/4: no overflow, no saturation.
    // -----------------------------------------------------------------------
    always_comb begin
        err_ext    = 23'(signed'(s1_e_q));
        deriv_ext  = {16'h0000, s1_d_q};
        prod_s     = err_ext * deriv_ext;
        prod_s_rnd = prod_s + RND_S;
        prod_s_shr = prod_s_rnd >>> 8;
        delta      = prod_s_shr[15:0];
    end

    // High bits beyond the proven range are intentionally dropped.
    logic unused_bits;
    assign unused_bits = &{1'b0, prod_u_rnd[16:15], prod_u_rnd[7:0],
                           prod_s_shr[22:16]};

    // -----------------------------------------------------------------------
    // Next-state logic: both stages load together on adv, hold otherwise.
    // -----------------------------------------------------------------------
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_d_d      = s1_d_q;
        s1_e_d      = s1_e_q;
        out_valid_d = out_valid_q;
        out_delta_d = out_delta_q;

        if (adv) begin
            s1_valid_d  = in_valid;
            s1_d_d      = deriv;
            s1_e_d      = in_err;
            out_valid_d = s1_valid_q;
            out_delta_d = delta;
        end

        // Counts output handshakes; natural 16-bit wrap.
        out_count_d = out_count_q + {15'h0000, out_xfer};
    end

    // -----------------------------------------------------------------------
    // State registers. Reset clears data as well as valids so the output
    // port reads 0x0000 out of reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours.
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_d_q      <= 7'h00;
            s1_e_q      <= 16'h0000;
            out_valid_q <= 1'b0;
            out_delta_q <= 16'h0000;
            out_count_q <= 16'h0000;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_d_q      <= s1_d_d;
            s1_e_q      <= s1_e_d;
            out_valid_q <= out_valid_d;
            out_delta_q <= out_delta_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_delta = out_delta_q;
    assign out_count = out_count_q;

endmodule
